lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// Character-LCD write controller: CPU stores are queued in a small FIFO and replayed
// onto the parallel LCD bus with programmable setup, enable, hold and settle timing.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned EN_CYC     = 12,
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned SHORT_WAIT = 2000,
    parameter int unsigned LONG_WAIT  = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_B = (HOLD_CYC > MAX_A) ? HOLD_CYC : MAX_A;
    localparam int unsigned MAX_C = (SHORT_WAIT > MAX_B) ? SHORT_WAIT : MAX_B;
    localparam int unsigned MAX_CYC = (LONG_WAIT > MAX_C) ? LONG_WAIT : MAX_C;
    localparam int unsigned TMR_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [8:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               pend_q;
    logic [8:0]         pend_entry_q;
    logic               ovf_q;
    logic               on_q;
    logic [7:0]         data_q;
    logic               rs_q;
    logic               en_q;
    logic               full, empty, pop, push, drop, long_cmd;
    logic               unused_wr_bits;

    assign unused_wr_bits = ^i_wr_data[28:9];

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // The FSM pops before the staged push lands, so a full FIFO still accepts a push
    // on the same edge that the head is consumed.
    assign push  = pend_q && (!full || pop);
    assign drop  = pend_q && full && !pop;

    // Clear and return-home need the long settle time on the controller side.
    assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    // Stores are staged for one cycle before entering the FIFO.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_q       <= 1'b0;
            pend_entry_q <= '0;
            on_q         <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            pend_q <= i_wr_en && !i_wr_data[30];
            if (i_wr_en) begin
                pend_entry_q <= i_wr_data[8:0];
                on_q         <= i_wr_data[31];
            end
            if (i_wr_en && i_wr_data[29]) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pend_entry_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                    tmr_d   = TMR_W'(SETUP_CYC - 1);
                end
            end
            StSetup: begin
                if (tmr_q == '0) begin
                    state_d = StPulse;
                    tmr_d   = TMR_W'(EN_CYC - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StPulse: begin
                if (tmr_q == '0) begin
                    state_d = StHold;
                    tmr_d   = TMR_W'(HOLD_CYC - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StHold: begin
                if (tmr_q == '0) begin
                    state_d = StWait;
                    tmr_d   = long_cmd ? TMR_W'(LONG_WAIT - 1) : TMR_W'(SHORT_WAIT - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StWait: begin
                if (tmr_q == '0) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // EN is registered so it is glitch-free and drops asynchronously with reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            en_q    <= (state_d == StPulse);
            if (pop) begin
                {rs_q, data_q} <= mem[rd_ptr_q];
            end
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = (state_q != StIdle) || !empty;

    // Status reads as all-zero while reset is held, including the empty flag.
    assign o_status = i_reset ? 32'h0 :
                      {on_q, 22'h0, ovf_q, empty, full, o_busy, 5'(count_q)};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed timing checks plus randomized stores compared each
// cycle against a queue-and-elapsed-time model of the LCD write protocol.
module tb_lcd_ctrl;

    localparam int S  = 2;
    localparam int E  = 3;
    localparam int H  = 2;
    localparam int SW = 5;
    localparam int LW = 20;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] o_status;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy;

    int n_vec  = 0;
    int n_fail = 0;

    lcd_ctrl #(
        .FIFO_DEPTH (D),
        .SETUP_CYC  (S),
        .EN_CYC     (E),
        .HOLD_CYC   (H),
        .SHORT_WAIT (SW),
        .LONG_WAIT  (LW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_status   (o_status),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, a transfer as "cycles since pop".
    logic [8:0] mq[$];
    bit         m_pend = 1'b0;
    logic [8:0] m_pend_e = '0;
    bit         m_active = 1'b0;
    int         m_el = 0;
    int         m_total = 0;
    logic [7:0] m_data = '0;
    bit         m_rs = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_on = 1'b0;
    bit         m_pop;
    logic [8:0] m_e;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_pend = 1'b0; m_active = 1'b0; m_el = 0; m_data = '0; m_rs = 1'b0;
            m_ovf = 1'b0; m_on = 1'b0;
        end else begin
            m_pop = !m_active && (mq.size() > 0);
            if (m_active) begin
                m_el++;
                if (m_el == m_total) m_active = 1'b0;
            end
            if (m_pop) begin
                m_e = mq.pop_front();
                m_data = m_e[7:0];
                m_rs = m_e[8];
                m_active = 1'b1;
                m_el = 0;
                m_total = S + E + H +
                          ((!m_e[8] && m_e[7:0] >= 8'd1 && m_e[7:0] <= 8'd3) ? LW : SW);
            end
            if (m_pend) begin
                if (mq.size() < D) mq.push_back(m_pend_e);
                else m_ovf = 1'b1;
            end
            if (wr_en && wr_data[29]) m_ovf = 1'b0;
            if (wr_en) m_on = wr_data[31];
            m_pend = wr_en && !wr_data[30];
            m_pend_e = wr_data[8:0];
        end
    end

    function automatic logic [31:0] exp_status();
        logic busy;
        busy = m_active || (mq.size() > 0);
        return {m_on, 22'h0, m_ovf, mq.size() == 0, mq.size() == D, busy, 5'(mq.size())};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            check("m_en", o_lcd_en, m_active && m_el >= S && m_el < S + E);
            check("m_data", o_lcd_data, m_data);
            check("m_rs", o_lcd_rs, m_rs);
            check("m_rw", o_lcd_rw, 1'b0);
            check("m_on", o_lcd_on, m_on);
            check("m_busy", o_busy, m_active || (mq.size() > 0));
            check("m_status", o_status, exp_status());
        end
    end

    task automatic set_wr(input bit en, input logic [31:0] d);
        @(negedge clk);
        wr_en = en;
        wr_data = d;
    endtask

    task automatic reset_zero_checks(input string tag);
        check({tag, "_en"}, o_lcd_en, 1'b0);
        check({tag, "_data"}, o_lcd_data, 8'h00);
        check({tag, "_rs"}, o_lcd_rs, 1'b0);
        check({tag, "_on"}, o_lcd_on, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_status"}, o_status, 32'h0);
    endtask

    int   rises[$];
    logic [7:0] rdata[$];
    logic pe;
    int   dens;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_zero_checks("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_status", o_status, 32'h0000_0080);

        // Single data write: SETUP at +2, EN over edges 4..7, idle at +14.
        set_wr(1'b1, 32'h0000_0141);
        @(posedge clk);
        #1;
        check("t1_busy_e0", o_busy, 1'b0);
        set_wr(1'b0, 32'h0);
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            check("t1_en", o_lcd_en, (e >= 4 && e < 7));
            check("t1_busy", o_busy, (e < 14));
            if (e >= 2) begin
                check("t1_data", o_lcd_data, 8'h41);
                check("t1_rs", o_lcd_rs, 1'b1);
            end
        end

        // Clear display takes the long wait.
        set_wr(1'b1, 32'h0000_0001);
        @(posedge clk);
        set_wr(1'b0, 32'h0);
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            check("t2_en", o_lcd_en, (e >= 4 && e < 7));
            check("t2_busy", o_busy, (e < 29));
        end

        // Back-to-back writes: EN rises 13 cycles apart.
        set_wr(1'b1, 32'h0000_0141);
        set_wr(1'b1, 32'h0000_0141);
        set_wr(1'b0, 32'h0);
        rises.delete();
        pe = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (o_lcd_en && !pe) rises.push_back(c);
            pe = o_lcd_en;
        end
        check("t2_rise_cnt", rises.size(), 2);
        if (rises.size() == 2) check("t2_gap", rises[1] - rises[0], 13);

        // Overflow: six stores while busy, four kept and replayed in order.
        set_wr(1'b1, 32'h0000_0155);
        repeat (3) set_wr(1'b0, 32'h0);
        for (int i = 0; i < 6; i++) set_wr(1'b1, 32'h0000_0130 + i);
        set_wr(1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("t3_status_full", o_status, 32'h0000_0164);
        rdata.delete();
        pe = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (o_lcd_en && !pe) rdata.push_back(o_lcd_data);
            pe = o_lcd_en;
        end
        check("t3_replay_cnt", rdata.size(), 4);
        for (int i = 0; i < rdata.size(); i++) check("t3_replay", rdata[i], 8'h30 + i);
        set_wr(1'b1, 32'h6000_0000);
        set_wr(1'b0, 32'h0);
        check("t3_ovf_clr", o_status[8], 1'b0);

        // On-only store: no push, no pulse.
        set_wr(1'b1, 32'hC000_0000);
        set_wr(1'b0, 32'h0);
        check("t4_on", o_lcd_on, 1'b1);
        check("t4_status", o_status, 32'h8000_0080);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("t4_no_en", o_lcd_en, 1'b0);
        end

        // Turning the panel off mid-pulse leaves the pulse intact.
        set_wr(1'b1, 32'h8000_0142);
        repeat (4) set_wr(1'b0, 32'h0);
        set_wr(1'b1, 32'h0000_0000);
        set_wr(1'b0, 32'h0);
        check("t4_off", o_lcd_on, 1'b0);
        check("t4_en_kept", o_lcd_en, 1'b1);
        check("t4_data", o_lcd_data, 8'h42);
        check("t4_rs", o_lcd_rs, 1'b1);
        @(posedge clk);
        #1;
        check("t4_en_still", o_lcd_en, 1'b1);
        @(posedge clk);
        #1;
        check("t4_en_fall", o_lcd_en, 1'b0);
        repeat (40) @(posedge clk);

        // Asynchronous reset during PULSE, then a normal transfer.
        set_wr(1'b1, 32'h0000_0141);
        repeat (4) set_wr(1'b0, 32'h0);
        @(posedge clk);
        #2;
        check("t5_pre_en", o_lcd_en, 1'b1);
        rst = 1'b1;
        #1;
        reset_zero_checks("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        set_wr(1'b1, 32'h0000_0141);
        @(posedge clk);
        set_wr(1'b0, 32'h0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            check("t5_en", o_lcd_en, (e >= 4 && e < 7));
            if (e == 1) check("t5_data_idle", o_lcd_data, 8'h00);
            if (e >= 2) check("t5_data", o_lcd_data, 8'h41);
        end
        repeat (20) @(posedge clk);

        // Randomized traffic with varying density and occasional resets.
        dens = 10;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] d;
            logic [7:0]  b;
            if (c % 300 == 0) dens = $urandom_range(2, 70);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom());
            d = {1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0), 20'h0, 1'($urandom_range(0, 1)), b};
            set_wr($urandom_range(0, 99) < dens, d);
            if (c == 1500 || c == 2600) begin
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                reset_zero_checks("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        set_wr(1'b0, 32'h0);
        repeat (5) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
